// File: rtl/disparity_search_ctrl.sv
// Purpose: sequences one pixel's disparity search (candidate issue, in-order SAD
//          collection, running minimum) and hands back the best disparity.
// Latency: first candidate on the cycle after start acceptance; at most one issue
//          per cycle; best_valid rises the cycle after the final SAD is accepted.
// Backpressure: cand_ready stalls issue with cand_disp held; best_ready holds the
//          result in DONE; start_ready is low for the whole search; sad_valid has
//          no backpressure.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start_valid/start_ready  - new centre pixel handshake
//   disp_limit               - last disparity to test (inclusive), latched at start
//   cand_valid/cand_ready    - candidate handshake towards window fetch / SAD path
//   cand_disp                - candidate disparity index
//   sad_valid, sad_in        - SAD for the oldest outstanding candidate
//   best_valid/best_ready    - result handshake
//   best_disp, best_sad      - disparity with minimum SAD (lowest index on ties)
//   busy                     - high whenever a search or result hand-off is active

module disparity_search_ctrl #(
  parameter int DISP_SIZE = 6,
  parameter int SAD_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [DISP_SIZE-1:0] disp_limit,
  output logic                 cand_valid,
  input  logic                 cand_ready,
  output logic [DISP_SIZE-1:0] cand_disp,
  input  logic                 sad_valid,
  input  logic [SAD_SIZE-1:0]  sad_in,
  output logic                 best_valid,
  input  logic                 best_ready,
  output logic [DISP_SIZE-1:0] best_disp,
  output logic [SAD_SIZE-1:0]  best_sad,
  output logic                 busy
);

  // One extra bit so a full 2^DISP_SIZE sweep terminates without wrapping.
  localparam int CNT_W = DISP_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state;
  logic [DISP_SIZE-1:0] limit_q;
  logic [CNT_W-1:0]     issue_cnt;
  logic [CNT_W-1:0]     result_cnt;

  logic [CNT_W-1:0]     limit_ext;
  logic                 issue_fire;
  logic                 issue_more;
  logic                 result_open;
  logic                 result_fire;
  logic                 result_last;
  logic                 sad_better;

  assign limit_ext   = {1'b0, limit_q};
  assign issue_fire  = cand_valid && cand_ready;
  // After this issue, is there still a candidate at or below the limit?
  assign issue_more  = issue_cnt < limit_ext;
  // Results beyond the limit (or outside SEARCH) are dropped on the floor.
  assign result_open = (state == SEARCH) && (result_cnt <= limit_ext);
  assign result_fire = result_open && sad_valid;
  assign result_last = (result_cnt == limit_ext);
  // Strict compare keeps the earliest (lowest) disparity on ties.
  assign sad_better  = sad_in < best_sad;

  // The issue counter is the candidate index; its low bits are the offered disparity.
  assign cand_disp = issue_cnt[DISP_SIZE-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      limit_q     <= '0;
      issue_cnt   <= '0;
      result_cnt  <= '0;
      start_ready <= 1'b1;
      cand_valid  <= 1'b0;
      best_valid  <= 1'b0;
      best_disp   <= '0;
      best_sad    <= '1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state       <= SEARCH;
            limit_q     <= disp_limit;
            issue_cnt   <= '0;
            result_cnt  <= '0;
            best_sad    <= '1;
            best_disp   <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            // Disparity 0 is always within any limit.
            cand_valid  <= 1'b1;
          end
        end

        SEARCH: begin
          // Issue side: advance only on an accepted handshake.
          if (issue_fire) begin
            issue_cnt  <= issue_cnt + 1'b1;
            cand_valid <= issue_more;
          end

          // Result side: independent of issue, in-order matching by result_cnt.
          if (result_fire) begin
            result_cnt <= result_cnt + 1'b1;
            if (sad_better) begin
              best_sad  <= sad_in;
              best_disp <= result_cnt[DISP_SIZE-1:0];
            end
            if (result_last) begin
              state      <= DONE;
              best_valid <= 1'b1;
              cand_valid <= 1'b0;
            end
          end
        end

        DONE: begin
          if (best_ready) begin
            state       <= IDLE;
            best_valid  <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          cand_valid  <= 1'b0;
          best_valid  <= 1'b0;
          start_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disparity_search_ctrl.sv
// Purpose: self-checking bench for disparity_search_ctrl with a behavioural SAD
//          datapath model (in-order, random latency) and a min-search reference.
// Latency/backpressure: exercised through cand_ready patterns and best_ready holds.

module tb_disparity_search_ctrl;

  localparam int DW = 6;
  localparam int SW = 16;
  localparam logic [SW-1:0] SAD_MAX = '1;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [DW-1:0] disp_limit;
  logic          cand_valid;
  logic          cand_ready;
  logic [DW-1:0] cand_disp;
  logic          sad_valid;
  logic [SW-1:0] sad_in;
  logic          best_valid;
  logic          best_ready;
  logic [DW-1:0] best_disp;
  logic [SW-1:0] best_sad;
  logic          busy;

  disparity_search_ctrl #(.DISP_SIZE(DW), .SAD_SIZE(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .disp_limit  (disp_limit),
    .cand_valid  (cand_valid),
    .cand_ready  (cand_ready),
    .cand_disp   (cand_disp),
    .sad_valid   (sad_valid),
    .sad_in      (sad_in),
    .best_valid  (best_valid),
    .best_ready  (best_ready),
    .best_disp   (best_disp),
    .best_sad    (best_sad),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int n_checks = 0;
  int n_fail   = 0;

  // SAD the modelled datapath returns for each disparity of the current pixel.
  int sads [64];

  // Observations from the last search.
  integer issues [$];
  int     issue_edges [$];
  integer obs_best_disp, obs_best_sad;
  int     obs_proto_err, obs_timeout, obs_leftover;
  int     obs_start_edge, obs_done_edge, obs_last_sad_edge;
  integer obs_cand_valid_done;

  // Reference: minimum SAD over 0..lim, earliest index among equals.
  function automatic int ref_sad(input int lim);
    int m;
    m = sads[0];
    for (int i = 1; i <= lim; i++) if (sads[i] < m) m = sads[i];
    return m;
  endfunction

  function automatic int ref_disp(input int lim);
    int m;
    m = ref_sad(lim);
    for (int i = 0; i <= lim; i++) if (sads[i] == m) return i;
    return -1;
  endfunction

  // -1 when exactly 0..lim were issued in order, else first bad position (-2 = count).
  function automatic int first_bad_issue(input int lim);
    if (issues.size() != lim + 1) return -2;
    for (int i = 0; i <= lim; i++) if (issues[i] !== i) return i;
    return -1;
  endfunction

  // Runs one search. Called and returns at 1 time unit after a rising edge.
  // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
  task automatic run_search(input int lim, input int ready_mode, input int lat_min,
                            input int lat_max, input int abort_after);
    int pend_disp [$];
    int pend_due [$];
    int results, budget, k, due, last_due, prev_disp;
    bit prev_stall, rdy;
    issues.delete();
    issue_edges.delete();
    obs_proto_err = 0; obs_timeout = 0; obs_last_sad_edge = -1;
    start_valid = 1'b1;
    disp_limit  = DW'(lim);
    @(posedge clk); #1;
    obs_start_edge = edge_n;
    start_valid = 1'b0;
    disp_limit  = DW'($urandom);
    results = 0; budget = 0; k = 0; last_due = 0; prev_stall = 0; prev_disp = 0;
    while (best_valid !== 1'b1) begin
      if (start_ready !== 1'b0 || busy !== 1'b1) obs_proto_err++;
      if (prev_stall && (cand_valid !== 1'b1 || cand_disp !== DW'(prev_disp))) obs_proto_err++;
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 3 == 0);
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      k++;
      cand_ready = rdy;
      if (cand_valid === 1'b1 && rdy) begin
        issues.push_back(cand_disp);
        issue_edges.push_back(edge_n + 1);
        due = edge_n + 1 + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_disp.push_back(int'(cand_disp));
        pend_due.push_back(due);
      end
      prev_stall = (cand_valid === 1'b1) && !rdy;
      prev_disp  = int'(cand_disp);
      if (pend_due.size() > 0 && pend_due[0] <= edge_n + 1) begin
        sad_valid = 1'b1;
        sad_in    = SW'(sads[pend_disp[0]]);
        void'(pend_disp.pop_front());
        void'(pend_due.pop_front());
        results++;
        obs_last_sad_edge = edge_n + 1;
      end else begin
        sad_valid = 1'b0;
        sad_in    = SW'($urandom);
      end
      @(posedge clk); #1;
      budget++;
      if (abort_after >= 0 && results == abort_after) begin
        sad_valid = 1'b0; cand_ready = 1'b0;
        return;
      end
      if (budget > BUDGET) begin
        obs_timeout = 1;
        break;
      end
    end
    sad_valid = 1'b0;
    cand_ready = 1'b0;
    obs_leftover = pend_due.size();
    obs_done_edge = edge_n;
    obs_best_disp = best_disp;
    obs_best_sad = best_sad;
    obs_cand_valid_done = cand_valid;
  endtask

  task automatic accept_result();
    best_ready = 1'b1;
    @(posedge clk); #1;
    best_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
    n_checks++; if (cand_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cand_valid: got %b want 0", cand_valid); end
    n_checks++; if (cand_disp !== '0) begin n_fail++; $display("FAIL reset_cand_disp: got %0d want 0", cand_disp); end
    n_checks++; if (best_valid !== 1'b0) begin n_fail++; $display("FAIL reset_best_valid: got %b want 0", best_valid); end
    n_checks++; if (best_disp !== '0) begin n_fail++; $display("FAIL reset_best_disp: got %0d want 0", best_disp); end
    n_checks++; if (best_sad !== SAD_MAX) begin n_fail++; $display("FAIL reset_best_sad: got %0h want %0h", best_sad, SAD_MAX); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: start_ready=%b busy=%b want 1/0", start_ready, busy); end
  endtask

  task automatic test_basic();
    sads[0] = 40; sads[1] = 12; sads[2] = 30; sads[3] = 25;
    run_search(3, 0, 2, 2, -1);
    n_checks++; if (first_bad_issue(3) != -1) begin n_fail++; $display("FAIL basic_issue_seq: bad position %0d (count %0d) want none", first_bad_issue(3), issues.size()); end
    n_checks++; if (issue_edges.size() != 4 || issue_edges[0] != obs_start_edge + 1 || issue_edges[issue_edges.size()-1] != obs_start_edge + 4) begin n_fail++; $display("FAIL basic_consecutive: %0d issues, start edge %0d, want edges %0d..%0d", issue_edges.size(), obs_start_edge, obs_start_edge + 1, obs_start_edge + 4); end
    n_checks++; if (obs_best_disp !== 1) begin n_fail++; $display("FAIL basic_best_disp: got %0d want 1", obs_best_disp); end
    n_checks++; if (obs_best_sad !== 12) begin n_fail++; $display("FAIL basic_best_sad: got %0d want 12", obs_best_sad); end
    n_checks++; if (obs_done_edge != obs_start_edge + 6 || obs_done_edge != obs_last_sad_edge) begin n_fail++; $display("FAIL basic_done_timing: done edge %0d last sad %0d want %0d", obs_done_edge, obs_last_sad_edge, obs_start_edge + 6); end
    n_checks++; if (obs_proto_err != 0 || obs_timeout != 0) begin n_fail++; $display("FAIL basic_protocol: errs %0d timeout %0d want 0/0", obs_proto_err, obs_timeout); end
    n_checks++; if (obs_cand_valid_done !== 0) begin n_fail++; $display("FAIL basic_cand_valid_in_done: got %0d want 0", obs_cand_valid_done); end
    accept_result();
    n_checks++; if (best_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_back_to_idle: bv=%b sr=%b busy=%b want 0/1/0", best_valid, start_ready, busy); end
  endtask

  task automatic test_tie();
    sads[0] = 9; sads[1] = 9; sads[2] = 9;
    run_search(2, 0, 1, 3, -1);
    n_checks++; if (obs_best_disp !== 0 || obs_best_sad !== 9) begin n_fail++; $display("FAIL tie_result: got disp %0d sad %0d want 0/9", obs_best_disp, obs_best_sad); end
    accept_result();
  endtask

  task automatic test_stall();
    for (int i = 0; i <= 4; i++) sads[i] = int'($urandom_range(200, 0));
    run_search(4, 1, 1, 4, -1);
    n_checks++; if (first_bad_issue(4) != -1) begin n_fail++; $display("FAIL stall_issue_seq: bad position %0d (count %0d) want none", first_bad_issue(4), issues.size()); end
    n_checks++; if (obs_proto_err != 0 || obs_timeout != 0) begin n_fail++; $display("FAIL stall_hold: errs %0d timeout %0d want 0/0", obs_proto_err, obs_timeout); end
    n_checks++; if (obs_best_disp !== ref_disp(4) || obs_best_sad !== ref_sad(4)) begin n_fail++; $display("FAIL stall_result: got %0d/%0d want %0d/%0d", obs_best_disp, obs_best_sad, ref_disp(4), ref_sad(4)); end
    accept_result();
  endtask

  task automatic test_single_hold();
    sads[0] = 7;
    run_search(0, 0, 1, 1, -1);
    n_checks++; if (issues.size() != 1 || obs_best_disp !== 0 || obs_best_sad !== 7) begin n_fail++; $display("FAIL single_result: issues %0d disp %0d sad %0d want 1/0/7", issues.size(), obs_best_disp, obs_best_sad); end
    // Stray SADs while the result is parked must not disturb it.
    for (int c = 0; c < 5; c++) begin
      sad_valid = 1'b1;
      sad_in = '0;
      @(posedge clk); #1;
      n_checks++; if (best_valid !== 1'b1 || best_disp !== '0 || best_sad !== SW'(7) || start_ready !== 1'b0 || cand_valid !== 1'b0) begin n_fail++; $display("FAIL single_hold_c%0d: bv=%b disp=%0d sad=%0d sr=%b cv=%b want 1/0/7/0/0", c, best_valid, best_disp, best_sad, start_ready, cand_valid); end
    end
    sad_valid = 1'b0;
    accept_result();
    n_checks++; if (best_valid !== 1'b0 || start_ready !== 1'b1) begin n_fail++; $display("FAIL single_release: bv=%b sr=%b want 0/1", best_valid, start_ready); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i <= 7; i++) sads[i] = 100 - 10 * i;
    run_search(7, 0, 2, 2, 2);
    rst = 1'b1;
    #1;
    n_checks++; if (start_ready !== 1'b1 || cand_valid !== 1'b0 || cand_disp !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: sr=%b cv=%b cd=%0d busy=%b want 1/0/0/0", start_ready, cand_valid, cand_disp, busy); end
    n_checks++; if (best_valid !== 1'b0 || best_disp !== '0 || best_sad !== SAD_MAX) begin n_fail++; $display("FAIL midreset_best: bv=%b disp=%0d sad=%0h want 0/0/%0h", best_valid, best_disp, best_sad, SAD_MAX); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    sads[0] = 5; sads[1] = 3;
    run_search(1, 0, 1, 2, -1);
    n_checks++; if (obs_best_disp !== 1 || obs_best_sad !== 3 || obs_timeout != 0) begin n_fail++; $display("FAIL midreset_new_search: got %0d/%0d timeout %0d want 1/3/0", obs_best_disp, obs_best_sad, obs_timeout); end
    accept_result();
  endtask

  task automatic test_full_range();
    for (int i = 0; i < 64; i++) sads[i] = 1000 - i;
    run_search(63, 0, 1, 3, -1);
    n_checks++; if (first_bad_issue(63) != -1) begin n_fail++; $display("FAIL full_issue_seq: bad position %0d (count %0d) want none", first_bad_issue(63), issues.size()); end
    n_checks++; if (obs_best_disp !== 63 || obs_best_sad !== 937) begin n_fail++; $display("FAIL full_result: got %0d/%0d want 63/937", obs_best_disp, obs_best_sad); end
    n_checks++; if (obs_timeout != 0 || obs_leftover != 0) begin n_fail++; $display("FAIL full_termination: timeout %0d leftover %0d want 0/0", obs_timeout, obs_leftover); end
    accept_result();
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 64; i++) sads[i] = int'(SAD_MAX);
    run_search(5, 2, 1, 4, -1);
    n_checks++; if (obs_best_disp !== 0 || obs_best_sad !== int'(SAD_MAX)) begin n_fail++; $display("FAIL all_ones_result: got %0d/%0h want 0/%0h", obs_best_disp, obs_best_sad, SAD_MAX); end
    accept_result();
  endtask

  task automatic test_back_to_back();
    int lim;
    for (int it = 0; it < 24; it++) begin
      lim = (it % 6 == 0) ? 63 : int'($urandom_range(20, 0));
      for (int i = 0; i < 64; i++)
        sads[i] = (it % 2 == 0) ? int'($urandom_range(15, 0)) : int'($urandom_range(65535, 0));
      n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_it%0d: got %b want 1", it, start_ready); end
      // Stray SAD while idle and on the start edge must be ignored.
      sad_valid = 1'b1;
      sad_in = '0;
      run_search(lim, int'($urandom_range(2, 0)), 1, 5, -1);
      n_checks++; if (obs_best_disp !== ref_disp(lim) || obs_best_sad !== ref_sad(lim)) begin n_fail++; $display("FAIL b2b_result_it%0d: lim %0d got %0d/%0d want %0d/%0d", it, lim, obs_best_disp, obs_best_sad, ref_disp(lim), ref_sad(lim)); end
      n_checks++; if (first_bad_issue(lim) != -1 || obs_proto_err != 0 || obs_timeout != 0) begin n_fail++; $display("FAIL b2b_protocol_it%0d: seq %0d errs %0d timeout %0d want -1/0/0", it, first_bad_issue(lim), obs_proto_err, obs_timeout); end
      n_checks++; if (obs_done_edge != obs_last_sad_edge) begin n_fail++; $display("FAIL b2b_done_timing_it%0d: done %0d last sad %0d", it, obs_done_edge, obs_last_sad_edge); end
      accept_result();
    end
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    disp_limit = '0;
    cand_ready = 1'b0;
    sad_valid = 1'b0;
    sad_in = '0;
    best_ready = 1'b0;
    for (int i = 0; i < 64; i++) sads[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_tie();
    test_stall();
    test_single_hold();
    test_reset_mid();
    test_full_range();
    test_all_ones();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disparity_search_ctrl.md
DISPARITY_SEARCH_CTRL -- requirements
Module: disparity_search_ctrl

Interface
REQ-001 SHALL have parameter DISP_SIZE, default 6, meaning the width of disparity indices (up to 64 candidates).
REQ-002 SHALL have parameter SAD_SIZE, default 16, meaning the width of the SAD values returned by the datapath.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start_valid, input, 1, a new centre pixel is ready for search.
REQ-006 SHALL have port start_ready, output, 1, the controller can accept a pixel.
REQ-007 SHALL have port disp_limit, input, DISP_SIZE, the last disparity to test, inclusive.
REQ-008 SHALL have port cand_valid, output, 1, a candidate disparity is offered to the window fetch and SAD path.
REQ-009 SHALL have port cand_ready, input, 1, the window fetch accepts the candidate.
REQ-010 SHALL have port cand_disp, output, DISP_SIZE, the candidate disparity index.
REQ-011 SHALL have port sad_valid, input, 1, a SAD result is present; it has no backpressure.
REQ-012 SHALL have port sad_in, input, SAD_SIZE, the SAD for the oldest outstanding candidate.
REQ-013 SHALL have port best_valid, output, 1, a search result is available.
REQ-014 SHALL have port best_ready, input, 1, the consumer accepts the result.
REQ-015 SHALL have port best_disp, output, DISP_SIZE, the disparity with minimum SAD.
REQ-016 SHALL have port best_sad, output, SAD_SIZE, the minimum SAD value.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement a state machine with states IDLE, SEARCH and DONE.
REQ-019 IDLE: start_ready=1; on start_valid, SHALL latch disp_limit, clear the issue counter and result counter, set best_sad to all-ones and best_disp to 0, and go to SEARCH.
REQ-020 SEARCH: cand_valid SHALL be 1 while the issue counter is at or below the latched limit; cand_disp SHALL equal the issue counter.
REQ-021 SHALL increment the issue counter only on a cand_valid && cand_ready cycle, giving at most one candidate per cycle.
REQ-022 cand_disp SHALL stay stable while cand_valid=1 and cand_ready=0.
REQ-023 In SEARCH, each sad_valid cycle SHALL be matched to the disparity equal to the result counter, then increment the result counter; results return in issue order with arbitrary latency ≥1 cycle.
REQ-024 SHALL update best_sad and best_disp only when sad_in < best_sad (strict), so on a tie the lowest disparity is kept.
REQ-025 Issue and result handling SHALL operate in the same cycle without interference.
REQ-026 SHALL enter DONE on the cycle the result for the latched limit is accepted; the final comparison is included in best_*.
REQ-027 DONE: best_valid=1; best_disp and best_sad SHALL be held stable until best_ready; on best_ready, go to IDLE.
REQ-028 start_ready SHALL be 0 in SEARCH and DONE; no back-to-back overlap between pixels.
REQ-029 SHALL ignore sad_valid outside SEARCH and after all results have been received.
REQ-030 disp_limit=0 SHALL produce exactly one candidate (disparity 0).
REQ-031 disp_limit=all-ones SHALL produce 2^DISP_SIZE candidates; counters SHALL be DISP_SIZE+1 bits so there is no wrap.
REQ-032 A SAD equal to all-ones on every candidate SHALL yield best_disp=0 and best_sad=all-ones.
REQ-033 The block SHALL contain no combinational path from sad_in to best_* outputs; best_* SHALL be registered.

Reset
REQ-034 On rst, the block SHALL go to IDLE asynchronously, including mid-search or in DONE; outstanding results SHALL be discarded.
REQ-035 Reset values SHALL be: start_ready=1, cand_valid=0, cand_disp=0, best_valid=0, best_disp=0, best_sad=all-ones, busy=0.

Verification
REQ-036 Use disp_limit=3 with cand_ready=1 and SADs 40,12,30,25 at latency 2 -> 4 candidates 0..3 issued on consecutive cycles; best_disp=1, best_sad=12.
REQ-037 Use disp_limit=2 with SADs 9,9,9 -> best_disp=0, best_sad=9 (tie rule).
REQ-038 Use disp_limit=4 with cand_ready toggled 1,0,0,1... -> cand_disp held while stalled; no index skipped or repeated; exactly 5 issues.
REQ-039 Use disp_limit=0 with SAD 7 -> one candidate; DONE with best_disp=0, best_sad=7; best_ready held 0 for 5 cycles -> outputs stable, start_ready=0.
REQ-040 Assert rst during SEARCH after 2 of 8 results -> next cycle IDLE and reset values; a new search with limit 1 and SADs 5,3 gives best_disp=1.
REQ-041 Use disp_limit=63 with decreasing SADs 1000..937 -> 64 issues, best_disp=63, best_sad=937; no counter wrap.
